// File: rtl/vga_sync_receiver_pkg.sv
// Shared 640x480 timing constants, CRC seed and sync-tracker state encoding
// for the VGA receive monitor.
package vga_sync_receiver_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'h1021;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } sync_state_e;

endpackage

// File: rtl/vga_sync_receiver_crc16_pix_step.sv
// One CRC-16-CCITT update over a 12-bit {r,g,b} pixel, MSB first.
module crc16_pix_step
  import vga_sync_receiver_pkg::*;
(
  input  logic [15:0] i_crc,
  input  logic [11:0] i_pix,
  output logic [15:0] o_crc
);

  logic [12:0][15:0] stage;

  assign stage[0] = i_crc;

  generate
    for (genvar gi = 0; gi < 12; gi++) begin : g_bit
      logic fb;
      assign fb = stage[gi][15] ^ i_pix[11-gi];
      assign stage[gi+1] = {stage[gi][14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
  endgenerate

  assign o_crc = stage[12];

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA receive monitor: tracks HS/VS timing on the pixel strobe, recovers x/y/de,
// reports timing faults and a per-frame CRC of the active pixels.
module vga_sync_receiver
  import vga_sync_receiver_pkg::*;
#(
  parameter int H_ACT   = H_ACTIVE,
  parameter int H_FRONT = H_FP,
  parameter int H_SYN   = H_SYNC,
  parameter int H_BACK  = H_BP,
  parameter int V_ACT   = V_ACTIVE,
  parameter int V_FRONT = V_FP,
  parameter int V_SYN   = V_SYNC,
  parameter int V_BACK  = V_BP
)(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_stb,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic [3:0]  i_r,
  input  logic [3:0]  i_g,
  input  logic [3:0]  i_b,
  output logic        o_locked,
  output logic        o_de,
  output logic [9:0]  o_x,
  output logic [8:0]  o_y,
  output logic        o_frame_done,
  output logic [15:0] o_frame_crc,
  output logic        o_err,
  output logic [7:0]  o_err_count
);

  localparam logic [10:0] H_TOT_W  = 11'(H_ACT + H_FRONT + H_SYN + H_BACK);
  localparam logic [10:0] H_ACT_LO = 11'(H_SYN + H_BACK);
  localparam logic [10:0] H_ACT_HI = 11'(H_SYN + H_BACK + H_ACT);
  localparam logic [9:0]  V_TOT_W  = 10'(V_ACT + V_FRONT + V_SYN + V_BACK);
  localparam logic [9:0]  V_ACT_LO = 10'(V_SYN + V_BACK);
  localparam logic [9:0]  V_ACT_HI = 10'(V_SYN + V_BACK + V_ACT);

  sync_state_e state_q, state_d;
  logic        hs_prev_q, hs_prev_d;
  logic        vs_prev_q, vs_prev_d;
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  line_idx_q, line_idx_d;
  logic [15:0] crc_q, crc_d;
  logic        locked_q, locked_d;
  logic        de_q, de_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] frame_crc_q, frame_crc_d;
  logic        err_q, err_d;
  logic [7:0]  err_count_q, err_count_d;

  logic        hs_fall, vs_fall;
  logic [10:0] h_cnt_inc, h_cnt_nxt;
  logic [9:0]  line_inc, line_nxt;
  logic        h_ok, v_ok, in_active;
  logic [15:0] crc_step;

  assign hs_fall   = hs_prev_q & ~i_hs;
  assign vs_fall   = vs_prev_q & ~i_vs;
  assign h_cnt_inc = (h_cnt_q == 11'h7FF) ? h_cnt_q : h_cnt_q + 11'd1;
  assign line_inc  = (line_idx_q == 10'h3FF) ? line_idx_q : line_idx_q + 10'd1;
  assign h_ok      = (h_cnt_inc == H_TOT_W);
  assign v_ok      = (line_inc == V_TOT_W);

  // VS takes precedence so a coincident HS/VS fall starts line 0, not line 1.
  assign h_cnt_nxt = hs_fall ? 11'd0 : h_cnt_inc;
  assign line_nxt  = vs_fall ? 10'd0 : (hs_fall ? line_inc : line_idx_q);
  assign in_active = (h_cnt_nxt >= H_ACT_LO) && (h_cnt_nxt < H_ACT_HI) &&
                     (line_nxt >= V_ACT_LO) && (line_nxt < V_ACT_HI);

  crc16_pix_step u_crc (
    .i_crc (crc_q),
    .i_pix ({i_r, i_g, i_b}),
    .o_crc (crc_step)
  );

  always_comb begin
    state_d      = state_q;
    hs_prev_d    = hs_prev_q;
    vs_prev_d    = vs_prev_q;
    h_cnt_d      = h_cnt_q;
    line_idx_d   = line_idx_q;
    crc_d        = crc_q;
    locked_d     = locked_q;
    de_d         = de_q;
    x_d          = x_q;
    y_d          = y_q;
    frame_done_d = 1'b0;
    frame_crc_d  = frame_crc_q;
    err_d        = 1'b0;
    err_count_d  = err_count_q;

    if (i_pix_stb) begin
      hs_prev_d  = i_hs;
      vs_prev_d  = i_vs;
      h_cnt_d    = h_cnt_nxt;
      line_idx_d = line_nxt;
      crc_d      = in_active ? crc_step : crc_q;

      case (state_q)
        ST_SEARCH: begin
          if (vs_fall) state_d = ST_MEASURE;
        end
        ST_MEASURE: begin
          if (hs_fall && !h_ok) begin
            state_d = ST_SEARCH;
          end else if (vs_fall) begin
            state_d = v_ok ? ST_LOCKED : ST_SEARCH;
            if (v_ok) crc_d = CRC_INIT;
          end
        end
        ST_LOCKED: begin
          if ((hs_fall && !h_ok) || (!hs_fall && h_cnt_nxt == H_TOT_W) ||
              (vs_fall && !v_ok) || (!vs_fall && line_nxt == V_TOT_W)) begin
            state_d     = ST_SEARCH;
            err_d       = 1'b1;
            err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
          end else if (vs_fall) begin
            frame_done_d = 1'b1;
            frame_crc_d  = crc_q;
            crc_d        = CRC_INIT;
          end
        end
        default: state_d = ST_SEARCH;
      endcase

      locked_d = (state_d == ST_LOCKED);
      de_d     = locked_d && in_active;
      x_d      = in_active ? 10'(h_cnt_nxt - H_ACT_LO) : 10'd0;
      y_d      = in_active ? 9'(line_nxt - V_ACT_LO) : 9'd0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_SEARCH;
      hs_prev_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      h_cnt_q      <= '0;
      line_idx_q   <= '0;
      crc_q        <= CRC_INIT;
      locked_q     <= 1'b0;
      de_q         <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      frame_done_q <= 1'b0;
      frame_crc_q  <= CRC_INIT;
      err_q        <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      hs_prev_q    <= hs_prev_d;
      vs_prev_q    <= vs_prev_d;
      h_cnt_q      <= h_cnt_d;
      line_idx_q   <= line_idx_d;
      crc_q        <= crc_d;
      locked_q     <= locked_d;
      de_q         <= de_d;
      x_q          <= x_d;
      y_q          <= y_d;
      frame_done_q <= frame_done_d;
      frame_crc_q  <= frame_crc_d;
      err_q        <= err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign o_locked     = locked_q;
  assign o_de         = de_q;
  assign o_x          = x_q;
  assign o_y          = y_q;
  assign o_frame_done = frame_done_q;
  assign o_frame_crc  = frame_crc_q;
  assign o_err        = err_q;
  assign o_err_count  = err_count_q;

endmodule
